// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, parity codes, default widths
package uart_pkg;

    // Default frame and timing widths.
    localparam int DATA_WIDTH = 8;
    localparam int PRESCALE_W = 6;

    // Parity type codes as driven on par_typ.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame FSM states, common to the transmit and receive sides.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - capture shift register and data bit index for the UART transmitter
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   i_load        load i_data and clear the bit index (frame acceptance)
//   i_shift       end of a DATA bit: shift right and advance the index
//   i_data        byte to capture
//   o_lsb         current data bit (LSB of the shift register)
//   o_lsb_next    bit that becomes the LSB after the next shift
//   o_ser_done    the bit index points at the last data bit
module uart_tx_serializer #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_lsb,
    output logic                  o_lsb_next,
    output logic                  o_ser_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_idx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= r_shift >> 1;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    assign o_lsb      = r_shift[0];
    assign o_ser_done = (r_idx == IDX_LAST);

    // The top registers tx_out one edge ahead, so it needs the bit that is
    // about to be shifted into the LSB position.
    generate
        if (DATA_WIDTH > 1) begin : g_next
            assign o_lsb_next = r_shift[1];
        end else begin : g_next_none
            assign o_lsb_next = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop
//
// Optional parity is built only when the macro UART_TX_PARITY_EN is defined;
// otherwise par_en/par_typ are ignored and every frame is start+data+stop.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   p_data      byte to transmit, captured at acceptance
//   data_valid  transmit request, accepted only while idle
//   par_en      parity bit enable, captured at acceptance
//   par_typ     0 = even, 1 = odd parity, captured at acceptance
//   prescale    clock cycles per bit (0 behaves as 1), captured at acceptance
//   tx_out      registered serial line, idles high
//   busy        registered frame-in-progress flag
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int PRESCALE_W = uart_pkg::PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tx_out,
    output logic                  busy
);

    uart_state_e           r_state;
    uart_state_e           w_state_nxt;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_tx;
    logic                  r_busy;

    logic [PRESCALE_W-1:0] w_cnt_last;
    logic                  w_bit_end;
    logic                  w_accept;
    logic                  w_ser_shift;
    logic                  w_lsb;
    logic                  w_lsb_next;
    logic                  w_ser_done;

`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_bit;
`else
    logic                  w_unused_par;
    assign w_unused_par = &{1'b0, par_en, par_typ};
`endif

    assign w_accept    = (r_state == IDLE) && data_valid;
    // prescale of 0 is treated as one cycle per bit.
    assign w_cnt_last  = (r_presc == '0) ? '0 : r_presc - 1'b1;
    assign w_bit_end   = (r_cnt == w_cnt_last);
    assign w_ser_shift = (r_state == DATA) && w_bit_end;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_accept),
        .i_shift    (w_ser_shift),
        .i_data     (p_data),
        .o_lsb      (w_lsb),
        .o_lsb_next (w_lsb_next),
        .o_ser_done (w_ser_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (data_valid) w_state_nxt = START;
            START:  if (w_bit_end) w_state_nxt = DATA;
            DATA: begin
                if (w_bit_end && w_ser_done) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = r_par_en ? PARITY : STOP;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_bit_end) w_state_nxt = STOP;
`endif
            STOP:   if (w_bit_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);

            if (w_accept) begin
                r_presc <= prescale;
            end

            if (r_state == IDLE || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // tx_out is driven from the state being entered so the line
            // changes on the same edge as the state.
            case (w_state_nxt)
                START: r_tx <= 1'b0;
                DATA: begin
                    if (r_state == START) begin
                        r_tx <= w_lsb;
                    end else if (w_bit_end) begin
                        r_tx <= w_lsb_next;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: r_tx <= r_par_bit;
`endif
                default: r_tx <= 1'b1;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= par_en;
            r_par_bit <= (^p_data) ^ (par_typ == PAR_ODD);
        end
    end
`endif

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level reference model
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic [PW-1:0] prescale;
    logic          tx_out;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    // Parameters of a frame chained behind the current one.
    logic [DW-1:0] n_d;
    logic          n_pe;
    logic          n_pt;
    logic [PW-1:0] n_ps;

    uart_tx #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int bit_cycles(input logic [PW-1:0] ps);
        return (ps == 0) ? 1 : int'(ps);
    endfunction

    function automatic bit parity_in_frame(input logic pe);
`ifdef UART_TX_PARITY_EN
        return pe;
`else
        return 1'b0;
`endif
    endfunction

    // Present a request at a falling edge; the next rising edge accepts it.
    task automatic kick(input logic [DW-1:0] d, input logic pe, input logic pt,
                        input logic [PW-1:0] ps);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(negedge CLK);
    endtask

    // Called at the first falling edge after acceptance. Checks every cycle of
    // the frame plus the idle cycle after it. mode 0: quiet inputs; mode 1:
    // random input churn; mode 2: churn plus a data_valid=1 with 8'h3C request
    // during the first half of the frame.
    task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic [PW-1:0] ps, input int mode, input bit chain,
                             input string tag);
        logic exp_bits[$];
        logic pbit;
        int   p;
        int   len;
        p = bit_cycles(ps);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
        if (parity_in_frame(pe)) begin
            pbit = (($countones(d) % 2) == 1) ^ pt;
            exp_bits.push_back(pbit);
        end
        exp_bits.push_back(1'b1);
        len = p * exp_bits.size();
        for (int k = 0; k < len; k++) begin
            chk({tag, "/tx"}, tx_out, exp_bits[k / p]);
            chk({tag, "/busy"}, busy, 1'b1);
            if (chain && k == len - 1) begin
                p_data     = n_d;
                par_en     = n_pe;
                par_typ    = n_pt;
                prescale   = n_ps;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
                if (mode >= 1) begin
                    p_data   = DW'($urandom);
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                    prescale = PW'($urandom);
                end
                if (mode == 2 && k < len / 2) begin
                    p_data     = 8'h3C;
                    data_valid = 1'b1;
                end
            end
            @(negedge CLK);
        end
        chk({tag, "/idle_tx"}, tx_out, 1'b1);
        chk({tag, "/idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pe;
        logic          pt;
        logic [PW-1:0] ps;

        RST        = 1'b1;
        p_data     = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = '0;
        #1;
        chk("reset_async_tx", tx_out, 1'b1);
        chk("reset_async_busy", busy, 1'b0);
        repeat (3) @(negedge CLK);
        chk("reset_tx", tx_out, 1'b1);
        chk("reset_busy", busy, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // Even parity, A5, 8 cycles per bit, inputs churning mid-frame.
        kick(8'hA5, 1'b1, 1'b0, 6'd8);
        run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1, 1'b0, "even_a5");

        // Odd parity cases.
        kick(8'h01, 1'b1, 1'b1, 6'd3);
        run_frame(8'h01, 1'b1, 1'b1, 6'd3, 0, 1'b0, "odd_01");
        kick(8'h03, 1'b1, 1'b1, 6'd3);
        run_frame(8'h03, 1'b1, 1'b1, 6'd3, 0, 1'b0, "odd_03");

        // No parity, all ones.
        kick(8'hFF, 1'b0, 1'b0, 6'd4);
        run_frame(8'hFF, 1'b0, 1'b0, 6'd4, 1, 1'b0, "nopar_ff");

        // Request while busy is dropped and nothing is queued.
        kick(8'h5A, 1'b1, 1'b0, 6'd2);
        run_frame(8'h5A, 1'b1, 1'b0, 6'd2, 2, 1'b0, "busy_req");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("busy_req_noqueue_busy", busy, 1'b0);
            chk("busy_req_noqueue_tx", tx_out, 1'b1);
        end

        // Back-to-back with data_valid held: one idle cycle between frames.
        n_d  = 8'h96;
        n_pe = 1'b1;
        n_pt = 1'b1;
        n_ps = 6'd3;
        kick(8'hC3, 1'b1, 1'b0, 6'd2);
        run_frame(8'hC3, 1'b1, 1'b0, 6'd2, 0, 1'b1, "b2b_first");
        @(negedge CLK);
        run_frame(8'h96, 1'b1, 1'b1, 6'd3, 0, 1'b0, "b2b_second");

        // Reset during DATA bit 3.
        kick(8'h08, 1'b1, 1'b0, 6'd4);
        data_valid = 1'b0;
        repeat (4 * 4 + 1) @(negedge CLK);
        chk("rst_mid_pre_tx", tx_out, 1'b1);
        chk("rst_mid_pre_busy", busy, 1'b1);
        RST = 1'b1;
        #1;
        chk("rst_mid_async_tx", tx_out, 1'b1);
        chk("rst_mid_async_busy", busy, 1'b0);
        @(negedge CLK);
        chk("rst_mid_held_tx", tx_out, 1'b1);
        chk("rst_mid_held_busy", busy, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        kick(8'h6E, 1'b0, 1'b0, 6'd3);
        run_frame(8'h6E, 1'b0, 1'b0, 6'd3, 0, 1'b0, "post_rst");

        // prescale of 0 behaves as 1.
        kick(8'hA5, 1'b1, 1'b1, 6'd0);
        run_frame(8'hA5, 1'b1, 1'b1, 6'd0, 1, 1'b0, "presc0");

        // par_en=1: parity bit only appears when the feature is built.
        kick(8'h4D, 1'b1, 1'b0, 6'd5);
        run_frame(8'h4D, 1'b1, 1'b0, 6'd5, 0, 1'b0, "par_en_build");

        // Randomised frames.
        for (int n = 0; n < 12; n++) begin
            d  = DW'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            ps = PW'($urandom_range(0, 5));
            kick(d, pe, pt, ps);
            run_frame(d, pe, pt, ps, 1, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
